// File: rtl/local_ni_if.sv
// Core- and router-facing signal bundle of the local network interface.
// The slave modport is the NI's view; the master modport is the environment
// (core plus router local port) driving it.
interface local_ni_if #(
    parameter int WD = 40
);
    logic          tx_valid;
    logic          tx_ready;
    logic [1:0]    tx_dst;
    logic [31:0]   tx_payload;
    logic          wr_en_local;
    logic [WD-1:0] wdata_local;
    logic          full_local;
    logic [WD-1:0] data_to_local;
    logic          wr_next_local_en;
    logic          next_full_local;
    logic          rx_valid;
    logic          rx_ready;
    logic [1:0]    rx_src;
    logic [2:0]    rx_seq;
    logic [31:0]   rx_payload;
    logic          rx_misroute;
    logic          rx_overflow;
    logic [15:0]   tx_cnt;
    logic [15:0]   rx_cnt;

    modport slave (
        input  tx_valid, tx_dst, tx_payload, full_local,
        input  data_to_local, wr_next_local_en, rx_ready,
        output tx_ready, wr_en_local, wdata_local, next_full_local,
        output rx_valid, rx_src, rx_seq, rx_payload,
        output rx_misroute, rx_overflow, tx_cnt, rx_cnt
    );

    modport master (
        output tx_valid, tx_dst, tx_payload, full_local,
        output data_to_local, wr_next_local_en, rx_ready,
        input  tx_ready, wr_en_local, wdata_local, next_full_local,
        input  rx_valid, rx_src, rx_seq, rx_payload,
        input  rx_misroute, rx_overflow, tx_cnt, rx_cnt
    );
endinterface

// File: rtl/local_ni.sv
// Local-port network interface of a mesh router node.
// TX: core payloads are framed into flits {dst,src,1,seq,payload}, queued and
//     injected into the router local FIFO one per cycle while it is not full.
// RX: flits from the router are queued for the core; next_full_local leaves
//     SKID slots of margin because the router stops one cycle late.
module local_ni #(
    parameter int         WD     = 40,
    parameter logic [1:0] MY_LOC = 2'b00,
    parameter int         TXD    = 4,
    parameter int         RXD    = 4,
    parameter int         SKID   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    local_ni_if.slave  bus
);
    localparam int TAW = $clog2(TXD);
    localparam int RAW = $clog2(RXD);
    localparam logic [TAW:0] TX_FULL_OCC = (TAW+1)'(TXD);
    localparam logic [TAW:0] TX_ONE      = (TAW+1)'(1);
    localparam logic [RAW:0] RX_FULL_OCC = (RAW+1)'(RXD);
    localparam logic [RAW:0] RX_ONE      = (RAW+1)'(1);
    localparam logic [RAW:0] RX_SKID     = (RAW+1)'(SKID);

    typedef enum logic {S_IDLE, S_SEND} tx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // TX side
    logic [WD-1:0] r_txq [TXD];
    logic [TAW:0]  r_tx_wp;
    logic [TAW:0]  r_tx_rp;
    logic [TAW:0]  w_tx_occ;
    logic          w_tx_full;
    logic          w_tx_empty;
    logic          w_tx_ready;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic [2:0]    r_seq;
    logic [WD-1:0] w_tx_flit;
    tx_state_t     r_state;
    tx_state_t     w_state_next;
    logic          w_wr_en_next;
    logic          r_wr_en;
    logic [WD-1:0] r_wdata;
    logic [15:0]   r_tx_cnt;

    // RX side; the valid marker and dst are not stored, only {src,seq,payload}
    logic [36:0]   r_rxq [RXD];
    logic [RAW:0]  r_rx_wp;
    logic [RAW:0]  r_rx_rp;
    logic [RAW:0]  w_rx_occ;
    logic [RAW:0]  w_rx_occ_next;
    logic [RAW:0]  w_rx_free;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_rx_pop;
    logic          w_rx_wr;
    logic          w_rx_drop;
    logic          w_rx_misdst;
    logic [36:0]   w_rx_head;
    logic          r_next_full;
    logic          r_misroute;
    logic          r_overflow;
    logic [15:0]   r_rx_cnt;
    logic          w_unused_vmark;

    assign w_tx_occ   = r_tx_wp - r_tx_rp;
    assign w_tx_full  = (w_tx_occ == TX_FULL_OCC);
    assign w_tx_empty = (w_tx_occ == '0);
    // Held low while reset is asserted so the core cannot push into a queue being cleared.
    assign w_tx_ready = rst_n && !w_tx_full;
    assign w_tx_push  = bus.tx_valid && w_tx_ready;
    assign w_tx_flit  = {bus.tx_dst, MY_LOC, 1'b1, r_seq, bus.tx_payload};

    // TX FSM next state: pop and inject the head whenever the router has room.
    always_comb begin
        w_state_next = r_state;
        w_tx_pop     = 1'b0;
        w_wr_en_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (!bus.full_local) begin
                    w_tx_pop     = 1'b1;
                    w_wr_en_next = 1'b1;
                    if ((w_tx_occ == TX_ONE) && !w_tx_push) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // TX FSM state, queue pointers and sequence number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_tx_push) begin
                r_tx_wp <= r_tx_wp + TX_ONE;
                r_seq   <= r_seq + 3'd1;
            end
            if (w_tx_pop) begin
                r_tx_rp <= r_tx_rp + TX_ONE;
            end
        end
    end

    // TX queue storage; flits are framed at enqueue time.
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_txq[r_tx_wp[TAW-1:0]] <= w_tx_flit;
        end
    end

    // Registered injection port; wdata holds its last flit while idle or blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en  <= 1'b0;
            r_wdata  <= '0;
            r_tx_cnt <= '0;
        end else begin
            r_wr_en <= w_wr_en_next;
            if (w_wr_en_next) begin
                r_wdata  <= r_txq[r_tx_rp[TAW-1:0]];
                r_tx_cnt <= sat_inc(r_tx_cnt);
            end
        end
    end

    assign w_rx_occ      = r_rx_wp - r_rx_rp;
    assign w_rx_full     = (w_rx_occ == RX_FULL_OCC);
    assign w_rx_empty    = (w_rx_occ == '0);
    assign w_rx_pop      = !w_rx_empty && bus.rx_ready;
    // A same-cycle read frees a slot, so a full queue still accepts the write.
    assign w_rx_wr       = bus.wr_next_local_en && (!w_rx_full || w_rx_pop);
    assign w_rx_drop     = bus.wr_next_local_en && w_rx_full && !w_rx_pop;
    assign w_rx_misdst   = bus.wr_next_local_en && (bus.data_to_local[39:38] != MY_LOC);
    assign w_rx_occ_next = w_rx_occ + (RAW+1)'(w_rx_wr) - (RAW+1)'(w_rx_pop);
    assign w_rx_free     = RX_FULL_OCC - w_rx_occ_next;
    assign w_rx_head     = r_rxq[r_rx_rp[RAW-1:0]];
    assign w_unused_vmark = bus.data_to_local[35];

    // RX queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_wr) begin
                r_rx_wp <= r_rx_wp + RX_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rp <= r_rx_rp + RX_ONE;
            end
        end
    end

    // RX queue storage.
    always_ff @(posedge clk) begin
        if (w_rx_wr) begin
            r_rxq[r_rx_wp[RAW-1:0]] <= {bus.data_to_local[37:36],
                                        bus.data_to_local[34:32],
                                        bus.data_to_local[31:0]};
        end
    end

    // RX backpressure with skid margin, sticky error flags and receive counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_full <= 1'b0;
            r_misroute  <= 1'b0;
            r_overflow  <= 1'b0;
            r_rx_cnt    <= '0;
        end else begin
            r_next_full <= (w_rx_free <= RX_SKID);
            if (w_rx_misdst) begin
                r_misroute <= 1'b1;
            end
            if (w_rx_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_rx_wr) begin
                r_rx_cnt <= sat_inc(r_rx_cnt);
            end
        end
    end

    assign bus.tx_ready        = w_tx_ready;
    assign bus.wr_en_local     = r_wr_en;
    assign bus.wdata_local     = r_wdata;
    assign bus.tx_cnt          = r_tx_cnt;
    assign bus.next_full_local = r_next_full;
    assign bus.rx_valid        = !w_rx_empty;
    assign bus.rx_src          = w_rx_head[36:35];
    assign bus.rx_seq          = w_rx_head[34:32];
    assign bus.rx_payload      = w_rx_head[31:0];
    assign bus.rx_misroute     = r_misroute;
    assign bus.rx_overflow     = r_overflow;
    assign bus.rx_cnt          = r_rx_cnt;
endmodule

// File: tb/tb_local_ni.sv
// Testbench for local_ni: a cycle table, directed multi-cycle sequences and a
// randomized run against a queue-based reference model.
module tb_local_ni;
    localparam int TXD  = 4;
    localparam int RXD  = 4;
    localparam int SKID = 2;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;

    local_ni_if #(.WD(40)) bus ();

    local_ni #(
        .WD(40), .MY_LOC(2'b00), .TXD(TXD), .RXD(RXD), .SKID(SKID)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [1:0]  dst;
        logic [31:0] pl;
        logic        fl;
        logic        rw;
        logic [39:0] rd;
        logic        rr;
        logic        e_wr;
        logic [39:0] e_wd;
        logic        e_rdy;
        logic        e_rv;
        logic [1:0]  e_rs;
        logic [2:0]  e_sq;
        logic [31:0] e_rp;
        logic        e_mis;
        logic [15:0] e_txc;
        logic [15:0] e_rxc;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tx_valid         = 1'b0;
        bus.tx_dst           = 2'b00;
        bus.tx_payload       = 32'h0;
        bus.full_local       = 1'b0;
        bus.data_to_local    = 40'h0;
        bus.wr_next_local_en = 1'b0;
        bus.rx_ready         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en",     64'(bus.wr_en_local),     64'(0));
        chk("rst_wdata",     64'(bus.wdata_local),     64'(0));
        chk("rst_next_full", 64'(bus.next_full_local), 64'(0));
        chk("rst_rx_valid",  64'(bus.rx_valid),        64'(0));
        chk("rst_misroute",  64'(bus.rx_misroute),     64'(0));
        chk("rst_overflow",  64'(bus.rx_overflow),     64'(0));
        chk("rst_tx_cnt",    64'(bus.tx_cnt),          64'(0));
        chk("rst_rx_cnt",    64'(bus.rx_cnt),          64'(0));
        chk("rst_tx_ready",  64'(bus.tx_ready),        64'(0));
        #3 rst_n = 1'b1;
        #1;
        chk("rst_tx_ready_after", 64'(bus.tx_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [39:0] m_txq[$];
    logic [39:0] m_rxq[$];
    logic [2:0]  m_seq;
    int          m_inj;
    int          m_rxc;
    logic        m_ovf;
    logic        m_mis;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[10];
        logic [39:0] got[$];
        int          first_c;
        int          last_c;
        int          pushes;
        int          pulses;
        int          stray;
        logic        will_push;

        rst_n = 1'b0;
        idle_inputs();

        // ---------------- cycle table ----------------
        vt[0] = '{1'b1, 2'b11, 32'hDEADBEEF, 1'b0, 1'b0, 40'h0, 1'b0,
                  1'b0, 40'h0, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 16'd0, 16'd0};
        vt[1] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 40'h0, 1'b0,
                  1'b0, 40'h0, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 16'd0, 16'd0};
        vt[2] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 40'h0, 1'b0,
                  1'b1, 40'hC8DEADBEEF, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 16'd1, 16'd0};
        vt[3] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 40'h2800000055, 1'b1,
                  1'b0, 40'hC8DEADBEEF, 1'b1, 1'b1, 2'b10, 3'd0, 32'h55, 1'b0, 16'd1, 16'd1};
        vt[4] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 40'h0, 1'b1,
                  1'b0, 40'hC8DEADBEEF, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 16'd1, 16'd1};
        vt[5] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 40'h4D00001234, 1'b0,
                  1'b0, 40'hC8DEADBEEF, 1'b1, 1'b1, 2'b00, 3'd5, 32'h1234, 1'b1, 16'd1, 16'd2};
        vt[6] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 40'h0, 1'b1,
                  1'b0, 40'hC8DEADBEEF, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b1, 16'd1, 16'd2};
        vt[7] = '{1'b1, 2'b01, 32'h000000A5, 1'b0, 1'b0, 40'h0, 1'b0,
                  1'b0, 40'hC8DEADBEEF, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b1, 16'd1, 16'd2};
        vt[8] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 40'h0, 1'b0,
                  1'b0, 40'hC8DEADBEEF, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b1, 16'd1, 16'd2};
        vt[9] = '{1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 40'h0, 1'b0,
                  1'b1, 40'h49000000A5, 1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b1, 16'd2, 16'd2};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.tx_valid         = vt[i].tv;
            bus.tx_dst           = vt[i].dst;
            bus.tx_payload       = vt[i].pl;
            bus.full_local       = vt[i].fl;
            bus.wr_next_local_en = vt[i].rw;
            bus.data_to_local    = vt[i].rd;
            bus.rx_ready         = vt[i].rr;
            step();
            chk($sformatf("tbl%0d_wr_en", i),    64'(bus.wr_en_local), 64'(vt[i].e_wr));
            chk($sformatf("tbl%0d_wdata", i),    64'(bus.wdata_local), 64'(vt[i].e_wd));
            chk($sformatf("tbl%0d_tx_ready", i), 64'(bus.tx_ready),    64'(vt[i].e_rdy));
            chk($sformatf("tbl%0d_rx_valid", i), 64'(bus.rx_valid),    64'(vt[i].e_rv));
            chk($sformatf("tbl%0d_misroute", i), 64'(bus.rx_misroute), 64'(vt[i].e_mis));
            chk($sformatf("tbl%0d_tx_cnt", i),   64'(bus.tx_cnt),      64'(vt[i].e_txc));
            chk($sformatf("tbl%0d_rx_cnt", i),   64'(bus.rx_cnt),      64'(vt[i].e_rxc));
            if (vt[i].e_rv) begin
                chk($sformatf("tbl%0d_rx_src", i),     64'(bus.rx_src),     64'(vt[i].e_rs));
                chk($sformatf("tbl%0d_rx_seq", i),     64'(bus.rx_seq),     64'(vt[i].e_sq));
                chk($sformatf("tbl%0d_rx_payload", i), 64'(bus.rx_payload), 64'(vt[i].e_rp));
            end
        end
        idle_inputs();

        // ---------------- TX blocked by full_local, then burst ----------------
        do_reset();
        bus.full_local = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.tx_valid   = 1'b1;
            bus.tx_dst     = 2'b01;
            bus.tx_payload = 32'h100 + 32'(i);
            step();
            chk($sformatf("blk_wr_en_push%0d", i), 64'(bus.wr_en_local), 64'(0));
        end
        bus.tx_valid = 1'b0;
        chk("blk_tx_ready_full", 64'(bus.tx_ready), 64'(0));
        repeat (3) step();
        chk("blk_wr_en_held", 64'(bus.wr_en_local), 64'(0));
        bus.full_local = 1'b0;
        got.delete();
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.wr_en_local) begin
                got.push_back(bus.wdata_local);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        chk("blk_pulses", 64'(got.size()), 64'(4));
        chk("blk_consecutive", 64'(last_c - first_c), 64'(3));
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("blk_flit%0d", i), 64'(got[i]),
                64'({2'b01, 2'b00, 1'b1, 3'(i), 32'h100 + 32'(i)}));
        end
        chk("blk_tx_ready_back", 64'(bus.tx_ready), 64'(1));

        // ---------------- RX fill, skid and overflow ----------------
        do_reset();
        bus.rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.wr_next_local_en = 1'b1;
            bus.data_to_local    = {2'b00, 2'b01, 1'b1, 3'(k), 32'(k)};
            step();
            chk($sformatf("rxf_next_full_%0d", k), 64'(bus.next_full_local), 64'(k >= 2));
            chk($sformatf("rxf_overflow_%0d", k),  64'(bus.rx_overflow),     64'(k == 5));
        end
        bus.wr_next_local_en = 1'b0;
        chk("rxf_rx_cnt", 64'(bus.rx_cnt), 64'(4));
        bus.rx_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("rxf_valid_%0d", j),   64'(bus.rx_valid),   64'(1));
            chk($sformatf("rxf_payload_%0d", j), 64'(bus.rx_payload), 64'(j));
            step();
            chk($sformatf("rxf_nf_drain_%0d", j), 64'(bus.next_full_local), 64'(j <= 2));
        end
        chk("rxf_empty", 64'(bus.rx_valid), 64'(0));
        chk("rxf_overflow_sticky", 64'(bus.rx_overflow), 64'(1));
        bus.rx_ready = 1'b0;

        // ---------------- seq wrap over 9 flits ----------------
        do_reset();
        pushes = 0;
        pulses = 0;
        for (int c = 0; c < 40 && pulses < 9; c++) begin
            bus.tx_valid   = (pushes < 9);
            bus.tx_dst     = 2'b10;
            bus.tx_payload = 32'(pushes);
            will_push      = bus.tx_valid && bus.tx_ready;
            step();
            if (will_push) pushes++;
            if (bus.wr_en_local) begin
                chk($sformatf("wrap_seq%0d", pulses),     64'(bus.wdata_local[34:32]), 64'(pulses % 8));
                chk($sformatf("wrap_payload%0d", pulses), 64'(bus.wdata_local[31:0]),  64'(pulses));
                pulses++;
            end
        end
        bus.tx_valid = 1'b0;
        chk("wrap_pulses", 64'(pulses), 64'(9));
        chk("wrap_tx_cnt", 64'(bus.tx_cnt), 64'(9));

        // ---------------- async reset mid-SEND ----------------
        do_reset();
        bus.wr_next_local_en = 1'b1;
        bus.data_to_local    = 40'h0800000001;
        step();
        bus.wr_next_local_en = 1'b0;
        bus.full_local = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.tx_valid   = 1'b1;
            bus.tx_dst     = 2'b11;
            bus.tx_payload = 32'hA000 + 32'(i);
            step();
        end
        bus.tx_valid   = 1'b0;
        bus.full_local = 1'b0;
        step();
        chk("ar_pre_wr_en", 64'(bus.wr_en_local), 64'(1));
        chk("ar_pre_rx_cnt", 64'(bus.rx_cnt), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wr_en",    64'(bus.wr_en_local), 64'(0));
        chk("ar_wdata",    64'(bus.wdata_local), 64'(0));
        chk("ar_tx_cnt",   64'(bus.tx_cnt),      64'(0));
        chk("ar_rx_cnt",   64'(bus.rx_cnt),      64'(0));
        chk("ar_rx_valid", 64'(bus.rx_valid),    64'(0));
        chk("ar_tx_ready", 64'(bus.tx_ready),    64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("ar_tx_ready_after", 64'(bus.tx_ready), 64'(1));
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.wr_en_local) stray++;
        end
        chk("ar_no_stale_flit", 64'(stray), 64'(0));
        chk("ar_tx_cnt_after", 64'(bus.tx_cnt), 64'(0));

        // ---------------- randomized run vs. reference model ----------------
        do_reset();
        m_txq.delete();
        m_rxq.delete();
        m_seq = 3'd0;
        m_inj = 0;
        m_rxc = 0;
        m_ovf = 1'b0;
        m_mis = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic        push;
            logic        rpop;
            logic        rwr;
            logic [39:0] flit;
            logic [1:0]  rdst;
            bus.tx_valid         = 1'($urandom_range(0, 1));
            bus.tx_dst           = 2'($urandom_range(0, 3));
            bus.tx_payload       = $urandom;
            bus.full_local       = ($urandom_range(0, 2) == 0);
            bus.wr_next_local_en = 1'($urandom_range(0, 1));
            rdst                 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            bus.data_to_local    = {rdst, 2'($urandom_range(0, 3)), 1'b1, 3'($urandom_range(0, 7)), $urandom};
            bus.rx_ready         = 1'($urandom_range(0, 1));

            push = bus.tx_valid && (m_txq.size() < TXD);
            flit = {bus.tx_dst, 2'b00, 1'b1, m_seq, bus.tx_payload};
            rpop = (m_rxq.size() > 0) && bus.rx_ready;
            rwr  = bus.wr_next_local_en && ((m_rxq.size() - int'(rpop)) < RXD);

            step();

            if (bus.wr_en_local) begin
                chk("rnd_inject_while_full", 64'(bus.full_local), 64'(0));
                if (m_txq.size() == 0) begin
                    chk("rnd_unexpected_flit", 64'(bus.wdata_local), 64'(0));
                end else begin
                    chk("rnd_tx_flit", 64'(bus.wdata_local), 64'(m_txq.pop_front()));
                end
                m_inj++;
            end
            if (push) begin
                m_txq.push_back(flit);
                m_seq = m_seq + 3'd1;
            end
            chk("rnd_tx_cnt",   64'(bus.tx_cnt),   64'(m_inj));
            chk("rnd_tx_ready", 64'(bus.tx_ready), 64'(m_txq.size() < TXD));

            if (rpop) void'(m_rxq.pop_front());
            if (bus.wr_next_local_en) begin
                if (rwr) begin
                    m_rxq.push_back(bus.data_to_local);
                    m_rxc++;
                end else begin
                    m_ovf = 1'b1;
                end
                if (bus.data_to_local[39:38] != 2'b00) m_mis = 1'b1;
            end
            chk("rnd_rx_valid", 64'(bus.rx_valid), 64'(m_rxq.size() > 0));
            if (m_rxq.size() > 0) begin
                chk("rnd_rx_src",     64'(bus.rx_src),     64'(m_rxq[0][37:36]));
                chk("rnd_rx_seq",     64'(bus.rx_seq),     64'(m_rxq[0][34:32]));
                chk("rnd_rx_payload", 64'(bus.rx_payload), 64'(m_rxq[0][31:0]));
            end
            chk("rnd_next_full", 64'(bus.next_full_local), 64'((RXD - m_rxq.size()) <= SKID));
            chk("rnd_overflow",  64'(bus.rx_overflow),     64'(m_ovf));
            chk("rnd_misroute",  64'(bus.rx_misroute),     64'(m_mis));
            chk("rnd_rx_cnt",    64'(bus.rx_cnt),          64'(m_rxc));
        end
        idle_inputs();
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.wr_en_local) begin
                if (m_txq.size() == 0) begin
                    chk("rnd_drain_unexpected", 64'(bus.wdata_local), 64'(0));
                end else begin
                    chk("rnd_drain_flit", 64'(bus.wdata_local), 64'(m_txq.pop_front()));
                end
                m_inj++;
            end
        end
        chk("rnd_drain_left", 64'(m_txq.size()), 64'(0));
        chk("rnd_drain_cnt",  64'(bus.tx_cnt),   64'(m_inj));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/local_ni.md
Name: local_ni

Overview:
- Network interface on the local port of a mesh router node.
- TX side: accepts payloads from the attached core, forms 40-bit flits and injects them into the router's local input FIFO (wr_en_local/wdata_local, backpressured by full_local).
- RX side: captures flits the router emits on its local output (data_to_local/wr_next_local_en) and buffers them for the core. It drives next_full_local with skid margin, because the router stalls its pipeline one cycle after next_full is seen.

Parameters:
- WD, 40, flit width; fixed flit layout below.
- MY_LOC, 2'b00, this node's location {y,x}, written into the src field and checked against the dst field on RX.
- TXD, 4, TX queue depth, power of 2.
- RXD, 4, RX queue depth, power of 2, must be at least SKID+1.
- SKID, 2, free-slot threshold: next_full_local asserts when free RX slots <= SKID.

Ports:
- clk  in  1  single clock; the router's wclk_local and its local-output side also run on clk at top level.
- rst_n  in  1  asynchronous reset, active-low.
- tx_valid  in  1  core has a payload to send.
- tx_ready  out  1  TX queue not full.
- tx_dst  in  2  destination location {y,x}.
- tx_payload  in  32  payload.
- wr_en_local  out  1  write strobe into the router local FIFO.
- wdata_local  out  WD  flit to the router.
- full_local  in  1  router local FIFO full.
- data_to_local  in  WD  flit from the router.
- wr_next_local_en  in  1  data_to_local is valid this cycle.
- next_full_local  out  1  backpressure to the router.
- rx_valid  out  1  RX flit available.
- rx_ready  in  1  core accepts the RX flit.
- rx_src  out  2  source field of the head RX flit.
- rx_seq  out  3  sequence field of the head RX flit.
- rx_payload  out  32  payload of the head RX flit.
- rx_misroute  out  1  sticky: a flit was received whose dst != MY_LOC.
- rx_overflow  out  1  sticky: a flit arrived while the RX queue was full.
- tx_cnt  out  16  flits injected, saturating.
- rx_cnt  out  16  flits received, saturating.

Behaviour:
- Flit layout:
  - [39:38] dst
  - [37:36] src (= MY_LOC)
  - [35] valid marker, always 1, so no real flit is all-zero; all-zero means idle in the router.
  - [34:32] seq
  - [31:0] payload
- Reset (rst_n low, async):
  - Both queues are emptied and seq returns to 0.
  - The TX FSM goes to IDLE.
  - All outputs go to 0: wr_en_local, wdata_local, next_full_local, rx_valid, the sticky flags, and both counters.
  - tx_ready is 0 while rst_n is low and 1 on the first cycle after release.
  - Reset mid-transfer discards all queued flits; no partial flit is emitted.
- TX enqueue:
  - A push happens when tx_valid && tx_ready on a clk edge.
  - The flit is built at enqueue time with the current seq; seq then increments mod 8.
  - tx_ready = !tx_queue_full, driven combinationally from registered occupancy.
- TX FSM, states IDLE / SEND:
  - IDLE -> SEND when the queue is non-empty.
  - In SEND, on a cycle with full_local==0: the registered outputs wr_en_local=1 and wdata_local=head flit take effect next cycle, and the head is popped.
  - If full_local==1: the next cycle has wr_en_local=0, wdata_local holds its last value, and there is no pop.
  - SEND -> IDLE when the last flit is popped and the queue is otherwise empty.
  - Throughput is 1 flit/cycle while full_local stays low. Minimum latency is push at edge N -> wr_en_local high in cycle N+2.
- TX simultaneous events: a push and a pop in the same cycle keep occupancy unchanged. A push is refused only when the queue is full (tx_ready=0).
- RX capture:
  - On wr_next_local_en==1 with the RX queue not full, data_to_local is written; rx_cnt increments, saturating at 16'hFFFF.
  - If the queue is full, the flit is dropped and rx_overflow is set; it stays set until reset.
  - If dst != MY_LOC, rx_misroute is set; the flit is still queued.
- RX read:
  - rx_valid = !rx_queue_empty.
  - rx_src, rx_seq and rx_payload show the head flit.
  - The head is popped on rx_valid && rx_ready.
  - A write and a read in the same cycle both proceed, including when the queue is full: the pop frees a slot first.
- Backpressure: next_full_local is registered and is 1 when (RXD - occupancy_next) <= SKID, else 0.
- Counters: tx_cnt increments once per wr_en_local pulse; both counters saturate and never wrap.
- Seq wraps 7 -> 0 without any error.

Test Plan:
1. Reset release, then push dst=2'b11, payload=32'hDEADBEEF -> two cycles later wr_en_local=1 for one cycle with wdata_local=40'hC8DEADBEEF, and tx_cnt=1.
2. Push 4 flits back-to-back with full_local held high -> tx_ready drops after the 4th push and no wr_en_local occurs. Release full_local -> 4 consecutive pulses with seq 0,1,2,3, and tx_ready returns.
3. Drive 3 RX flits (dst=00) with rx_ready=0, RXD=4, SKID=2 -> next_full_local=1 after the 2nd flit. A 4th flit still fits and rx_overflow stays 0. A 5th flit is dropped and rx_overflow=1.
4. RX flit 40'h28_0000_0055 (dst=00, src=10, seq=0) with rx_ready=1 -> rx_valid=1 for one cycle, rx_src=2'b10, rx_payload=32'h55, and rx_misroute=0. A flit with dst=01 -> rx_misroute=1 and the flit is still delivered.
5. Push 9 flits -> the 9th carries seq=0 (wrap), and there is no error.
6. Drop rst_n asynchronously mid-SEND with 3 flits queued -> wr_en_local=0 immediately and the counters clear. After release, no stale flit is injected and tx_ready=1.
